// File: rtl/p_div_if.sv
// p_div_if: request/response bundle for the packed divider.
//   valid  - request, held with stable operands until ready
//   ready  - single-cycle completion strobe
//   div/rem - result select (exactly one set)
//   pw     - one-hot pack width (bit0=32 .. bit4=2)
//   crs1/crs2 - packed dividends / divisors
//   result - packed quotients or remainders, valid while ready
interface p_div_if;
    logic        valid;
    logic        ready;
    logic        div;
    logic        rem;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] result;

    modport master (output valid, div, rem, pw, crs1, crs2, input ready, result);
    modport slave  (input valid, div, rem, pw, crs1, crs2, output ready, result);
endinterface

// File: rtl/p_div.sv
// p_div: iterative packed unsigned divider / remainder unit.
// Restoring shift-subtract; every lane retires one quotient bit per cycle
// through one 32-bit subtractor whose borrow chain is cut at lane boundaries.
// Ports:
//   clock  - core clock
//   resetn - asynchronous active-low reset
//   bus    - p_div_if slave (valid/ready handshake, operands, result)
module p_div (
    input  logic    clock,
    input  logic    resetn,
    p_div_if.slave  bus
);
    logic [5:0]  count;
    logic [31:0] r_q;     // packed partial remainders
    logic [31:0] q_q;     // packed dividend/quotient shift register

    logic [5:0]  w;       // lane width
    logic [4:0]  wm1;     // lane width - 1, doubles as in-lane bit mask
    logic        legal;
    logic        done;
    logic [31:0] qw;
    logic [31:0] slow;    // low W bits of S per lane
    logic [31:0] diff;    // low W bits of T per lane
    logic [31:0] lbit;    // quotient bit, valid at each lane MSB position
    logic [31:0] rn;
    logic [31:0] qn;

    always_comb begin
        w     = 6'd32;
        wm1   = 5'd31;
        legal = 1'b1;
        case (bus.pw)
            5'b00001: begin w = 6'd32; wm1 = 5'd31; end
            5'b00010: begin w = 6'd16; wm1 = 5'd15; end
            5'b00100: begin w = 6'd8;  wm1 = 5'd7;  end
            5'b01000: begin w = 6'd4;  wm1 = 5'd3;  end
            5'b10000: begin w = 6'd2;  wm1 = 5'd1;  end
            default:  legal = 1'b0;
        endcase
        if (bus.div == bus.rem) legal = 1'b0;
    end

    // No load cycle: the first iteration reads the dividend directly.
    assign qw = (count == 6'd0) ? bus.crs1 : q_q;

    // >= rather than == so that operands changed mid-operation (e.g. a
    // narrower pw) still terminate instead of overshooting forever.
    assign done = legal ? (count >= w) : 1'b1;

    assign bus.ready  = resetn & bus.valid & done;
    assign bus.result = (bus.ready & legal) ? (bus.div ? q_q : r_q) : 32'd0;

    // Packed subtract: S_low - D per lane. The top bit of S is R_lane[W-1];
    // T has no borrow when that bit is set or the low part did not borrow.
    always_comb begin
        logic [4:0] idx;
        logic [4:0] top;
        logic       lsb;
        logic       s;
        logic       bi;
        logic       b;
        slow = '0;
        diff = '0;
        lbit = '0;
        rn   = '0;
        qn   = '0;
        b    = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = 5'(i);
            lsb = ((idx & wm1) == 5'd0);
            s   = lsb ? qw[idx | wm1] : r_q[idx - 5'd1];
            bi  = lsb ? 1'b0 : b;
            slow[i] = s;
            diff[i] = s ^ bus.crs2[i] ^ bi;
            b       = (~s & bus.crs2[i]) | (~(s ^ bus.crs2[i]) & bi);
            if ((idx & wm1) == wm1)
                lbit[i] = r_q[i] | ~b;
        end
        for (int i = 0; i < 32; i++) begin
            idx = 5'(i);
            top = idx | wm1;
            lsb = ((idx & wm1) == 5'd0);
            rn[i] = lbit[top] ? diff[i] : slow[i];
            qn[i] = lsb ? lbit[top] : qw[idx - 5'd1];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= 6'd0;
            r_q   <= '0;
            q_q   <= '0;
        end else if (!bus.valid || done) begin
            // abort, completion, or illegal request: ready for a fresh op
            count <= 6'd0;
            r_q   <= '0;
            q_q   <= '0;
        end else begin
            count <= count + 6'd1;
            r_q   <= rn;
            q_q   <= qn;
        end
    end
endmodule
